// File: rtl/dragon_body.sv
// Trail of body segments that follows the dragon head one tile step behind.
// Tracks visible length, and answers registered occupancy/self-collision queries.
module dragon_body #(
  parameter int unsigned MAX_SEGMENTS = 8,
  parameter int unsigned INIT_LENGTH  = 3,
  parameter logic [7:0]  RESET_POS    = 8'h00
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [7:0]                i_head_pos,
  input  logic [1:0]                i_head_dir,
  input  logic                      i_grow,
  input  logic                      i_shrink,
  input  logic [7:0]                i_query_pos,
  output logic [8*MAX_SEGMENTS-1:0] o_seg_pos,
  output logic [2*MAX_SEGMENTS-1:0] o_seg_dir,
  output logic [MAX_SEGMENTS-1:0]   o_seg_active,
  output logic [3:0]                o_length,
  output logic                      o_body_full,
  output logic                      o_body_empty,
  output logic                      o_move_event,
  output logic                      o_query_hit,
  output logic [3:0]                o_query_index,
  output logic                      o_head_overlap
);

  localparam logic [3:0] MaxLen  = 4'(MAX_SEGMENTS);
  localparam logic [3:0] InitLen = 4'(INIT_LENGTH);

  logic [7:0] r_slot [MAX_SEGMENTS];
  logic [1:0] r_dir  [MAX_SEGMENTS];
  logic [7:0] r_prev_head;
  logic [1:0] r_prev_dir;
  logic [3:0] r_length;
  logic       r_move_event;
  logic       r_query_hit;
  logic [3:0] r_query_index;
  logic       r_head_overlap;

  logic                    w_move;
  logic [3:0]              w_length_d;
  logic [MAX_SEGMENTS-1:0] w_active;
  logic                    w_query_hit;
  logic [3:0]              w_query_index;
  logic                    w_head_overlap;

  assign w_move = (i_head_pos != r_prev_head);

  always_comb begin
    w_length_d = r_length;
    if (i_grow && !i_shrink && (r_length != MaxLen)) begin
      w_length_d = r_length + 4'd1;
    end else if (i_shrink && !i_grow && (r_length != 4'd0)) begin
      w_length_d = r_length - 4'd1;
    end
  end

  always_comb begin
    w_active = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      w_active[i] = (4'(i) < r_length);
    end
  end

  // Descending scan so the lowest matching slot is the last one written.
  always_comb begin
    w_query_hit    = 1'b0;
    w_query_index  = 4'd0;
    w_head_overlap = 1'b0;
    for (int i = MAX_SEGMENTS - 1; i >= 0; i--) begin
      if (w_active[i] && (r_slot[i] == i_query_pos)) begin
        w_query_hit   = 1'b1;
        w_query_index = 4'(i);
      end
      if (w_active[i] && (r_slot[i] == i_head_pos)) begin
        w_head_overlap = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_SEGMENTS; i++) begin
        r_slot[i] <= RESET_POS;
        r_dir[i]  <= 2'b00;
      end
      r_prev_head    <= RESET_POS;
      r_prev_dir     <= 2'b00;
      r_length       <= InitLen;
      r_move_event   <= 1'b0;
      r_query_hit    <= 1'b0;
      r_query_index  <= 4'd0;
      r_head_overlap <= 1'b0;
    end else begin
      r_prev_head    <= i_head_pos;
      r_prev_dir     <= i_head_dir;
      r_length       <= w_length_d;
      r_move_event   <= w_move;
      r_query_hit    <= w_query_hit;
      r_query_index  <= w_query_index;
      r_head_overlap <= w_head_overlap;
      // Every slot shifts, active or not, so regrowth reveals real history.
      if (w_move) begin
        r_slot[0] <= r_prev_head;
        r_dir[0]  <= r_prev_dir;
        for (int i = 1; i < MAX_SEGMENTS; i++) begin
          r_slot[i] <= r_slot[i-1];
          r_dir[i]  <= r_dir[i-1];
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_SEGMENTS; g++) begin : g_pack
    assign o_seg_pos[8*g +: 8] = r_slot[g];
    assign o_seg_dir[2*g +: 2] = r_dir[g];
  end

  assign o_seg_active   = w_active;
  assign o_length       = r_length;
  assign o_body_full    = (r_length == MaxLen);
  assign o_body_empty   = (r_length == 4'd0);
  assign o_move_event   = r_move_event;
  assign o_query_hit    = r_query_hit;
  assign o_query_index  = r_query_index;
  assign o_head_overlap = r_head_overlap;

endmodule

// File: tb/tb_dragon_body.sv
// Bench for dragon_body: directed scenarios plus random traffic against a queue-based trail model.
module tb_dragon_body;

  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  head_pos = 8'h00;
  logic [1:0]  head_dir = 2'b00;
  logic        grow = 1'b0;
  logic        shrink = 1'b0;
  logic [7:0]  query_pos = 8'h00;
  logic [63:0] seg_pos;
  logic [15:0] seg_dir;
  logic [7:0]  seg_active;
  logic [3:0]  length;
  logic        body_full, body_empty, move_event, query_hit, head_overlap;
  logic [3:0]  query_index;

  int n_vec = 0;
  int n_err = 0;

  dragon_body #(.MAX_SEGMENTS(8), .INIT_LENGTH(3), .RESET_POS(8'h00)) dut (
    .i_clk(clk), .i_reset(reset), .i_head_pos(head_pos), .i_head_dir(head_dir),
    .i_grow(grow), .i_shrink(shrink), .i_query_pos(query_pos),
    .o_seg_pos(seg_pos), .o_seg_dir(seg_dir), .o_seg_active(seg_active), .o_length(length),
    .o_body_full(body_full), .o_body_empty(body_empty), .o_move_event(move_event),
    .o_query_hit(query_hit), .o_query_index(query_index), .o_head_overlap(head_overlap)
  );

  always #5 clk = ~clk;

  // Reference model: trail as a queue of {dir,pos}, newest entry at the front.
  logic [9:0] m_trail[$];
  logic [7:0] m_prev_head;
  logic [1:0] m_prev_dir;
  int         m_len;
  bit         m_move, m_qhit, m_ovl;
  int         m_qidx;

  task automatic model_reset();
    m_trail = {};
    for (int i = 0; i < MAXS; i++) m_trail.push_back(10'h000);
    m_prev_head = 8'h00;
    m_prev_dir  = 2'b00;
    m_len  = 3;
    m_move = 0; m_qhit = 0; m_ovl = 0; m_qidx = 0;
  endtask

  task automatic model_edge();
    bit moved;
    int nl;
    logic [9:0] e;
    moved = (head_pos != m_prev_head);
    m_qhit = 0; m_qidx = 0; m_ovl = 0;
    for (int i = 0; i < m_len; i++) begin
      e = m_trail[i];
      if (!m_qhit && e[7:0] == query_pos) begin m_qhit = 1; m_qidx = i; end
      if (e[7:0] == head_pos) m_ovl = 1;
    end
    if (moved) begin
      m_trail.push_front({m_prev_dir, m_prev_head});
      void'(m_trail.pop_back());
    end
    nl = m_len + int'(grow) - int'(shrink);
    if (nl < 0) nl = 0;
    if (nl > MAXS) nl = MAXS;
    m_len = nl;
    m_move = moved;
    m_prev_head = head_pos;
    m_prev_dir  = head_dir;
  endtask

  function automatic logic [63:0] exp_pos();
    logic [9:0] e;
    exp_pos = '0;
    for (int i = 0; i < MAXS; i++) begin e = m_trail[i]; exp_pos[8*i +: 8] = e[7:0]; end
  endfunction

  function automatic logic [15:0] exp_dir();
    logic [9:0] e;
    exp_dir = '0;
    for (int i = 0; i < MAXS; i++) begin e = m_trail[i]; exp_dir[2*i +: 2] = e[9:8]; end
  endfunction

  function automatic logic [7:0] exp_active();
    exp_active = 8'((16'd1 << m_len) - 16'd1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    head_pos = 8'h00; head_dir = 2'b00; grow = 0; shrink = 0; query_pos = 8'h00;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #12;
    n_vec++; if (length !== 4'd3) begin n_err++; $display("FAIL reset_len_held: got %0d want 3", length); end
    n_vec++; if (seg_pos !== 64'h0) begin n_err++; $display("FAIL reset_pos_held: got %h want 0", seg_pos); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_vec++; if (seg_pos !== 64'h0) begin n_err++; $display("FAIL reset_pos: got %h want 0", seg_pos); end
      n_vec++; if (length !== 4'd3) begin n_err++; $display("FAIL reset_len: got %0d want 3", length); end
      n_vec++; if (seg_active !== 8'b0000_0111) begin n_err++; $display("FAIL reset_active: got %b want 00000111", seg_active); end
      n_vec++; if (move_event !== 1'b0) begin n_err++; $display("FAIL reset_move: got %b want 0", move_event); end
    end
  endtask

  task automatic run_path();
    logic [7:0] p [4] = '{8'h00, 8'h10, 8'h20, 8'h21};
    logic [1:0] d [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    int pulses = 0;
    for (int k = 0; k < 4; k++) begin
      head_pos = p[k]; head_dir = d[k];
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (move_event === 1'b1) pulses++;
      end
    end
    n_vec++; if (pulses != 3) begin n_err++; $display("FAIL path_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_path();
    run_path();
    n_vec++; if (seg_pos[23:0] !== 24'h00_10_20) begin n_err++; $display("FAIL path_pos: got %h want 001020", seg_pos[23:0]); end
    n_vec++; if (seg_dir[5:0] !== 6'b01_01_10) begin n_err++; $display("FAIL path_dir: got %b want 010110", seg_dir[5:0]); end
    n_vec++; if (seg_pos !== exp_pos()) begin n_err++; $display("FAIL path_trail: got %h want %h", seg_pos, exp_pos()); end
    n_vec++; if (length !== 4'd3) begin n_err++; $display("FAIL path_len: got %0d want 3", length); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 7; k++) begin grow = 1; cyc(); grow = 0; end
    n_vec++; if (length !== 4'd8) begin n_err++; $display("FAIL sat_len_max: got %0d want 8", length); end
    n_vec++; if (body_full !== 1'b1) begin n_err++; $display("FAIL sat_full: got %b want 1", body_full); end
    n_vec++; if (seg_active !== 8'hFF) begin n_err++; $display("FAIL sat_active_full: got %b want ff", seg_active); end
    for (int k = 0; k < 9; k++) begin shrink = 1; cyc(); shrink = 0; end
    n_vec++; if (length !== 4'd0) begin n_err++; $display("FAIL sat_len_min: got %0d want 0", length); end
    n_vec++; if (body_empty !== 1'b1) begin n_err++; $display("FAIL sat_empty: got %b want 1", body_empty); end
    n_vec++; if (seg_active !== 8'h00) begin n_err++; $display("FAIL sat_active_empty: got %b want 0", seg_active); end
    n_vec++; if (body_full !== 1'b0) begin n_err++; $display("FAIL sat_not_full: got %b want 0", body_full); end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) begin grow = 1; cyc(); grow = 0; end
    grow = 1; shrink = 1; cyc(); grow = 0; shrink = 0;
    n_vec++; if (length !== 4'd3) begin n_err++; $display("FAIL both_len: got %0d want 3", length); end
    head_pos = 8'h22; cyc(); cyc();
    // Trail is now 21,20,10,...; grow together with a move exposes old slot2 in slot3.
    grow = 1; head_pos = 8'h23; cyc(); grow = 0;
    n_vec++; if (length !== 4'd4) begin n_err++; $display("FAIL growmove_len: got %0d want 4", length); end
    n_vec++; if (seg_pos[31:24] !== 8'h10) begin n_err++; $display("FAIL growmove_slot3: got %h want 10", seg_pos[31:24]); end
    n_vec++; if (seg_active !== 8'h0F) begin n_err++; $display("FAIL growmove_active: got %b want 0f", seg_active); end
  endtask

  task automatic test_query();
    do_reset();
    run_path();
    shrink = 1; cyc(); shrink = 0;
    query_pos = 8'h10; cyc();
    n_vec++; if (query_hit !== 1'b1) begin n_err++; $display("FAIL q10_hit: got %b want 1", query_hit); end
    n_vec++; if (query_index !== 4'd1) begin n_err++; $display("FAIL q10_idx: got %0d want 1", query_index); end
    query_pos = 8'h00; cyc();
    n_vec++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL q00_hit: got %b want 0", query_hit); end
    n_vec++; if (query_index !== 4'd0) begin n_err++; $display("FAIL q00_idx: got %0d want 0", query_index); end
    n_vec++; if (head_overlap !== 1'b0) begin n_err++; $display("FAIL ovl_before: got %b want 0", head_overlap); end
    query_pos = 8'h20; head_pos = 8'h20; cyc();
    n_vec++; if (head_overlap !== 1'b1) begin n_err++; $display("FAIL ovl_hit: got %b want 1", head_overlap); end
    n_vec++; if (query_hit !== 1'b1 || query_index !== 4'd0) begin
      n_err++; $display("FAIL q20: got hit %b idx %0d want hit 1 idx 0", query_hit, query_index);
    end
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 3; k++) begin grow = 1; cyc(); grow = 0; end
    n_vec++; if (length !== 4'd5) begin n_err++; $display("FAIL mid_len5: got %0d want 5", length); end
    head_pos = 8'h30; cyc();
    #2; reset = 1'b1; #1;
    n_vec++; if (length !== 4'd3) begin n_err++; $display("FAIL mid_len: got %0d want 3", length); end
    n_vec++; if (seg_pos !== 64'h0 || seg_dir !== 16'h0) begin
      n_err++; $display("FAIL mid_trail: got %h/%h want 0/0", seg_pos, seg_dir);
    end
    n_vec++; if (move_event !== 1'b0 || query_hit !== 1'b0 || head_overlap !== 1'b0) begin
      n_err++; $display("FAIL mid_flags: got %b%b%b want 000", move_event, query_hit, head_overlap);
    end
    model_reset();
    head_pos = 8'h00; head_dir = 2'b00; query_pos = 8'h00;
    @(posedge clk); #2; reset = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_vec++; if (seg_pos !== 64'h0 || move_event !== 1'b0) begin
        n_err++; $display("FAIL mid_hold: got %h move %b want 0 move 0", seg_pos, move_event);
      end
    end
    head_pos = 8'h45; cyc();
    n_vec++; if (move_event !== 1'b1) begin n_err++; $display("FAIL mid_firstmove: got %b want 1", move_event); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(1, 0) == 1) head_pos = {4'($urandom_range(3, 0)), 4'($urandom_range(3, 0))};
      head_dir  = 2'($urandom_range(3, 0));
      grow      = ($urandom_range(4, 0) == 0);
      shrink    = ($urandom_range(4, 0) == 0);
      query_pos = {4'($urandom_range(3, 0)), 4'($urandom_range(3, 0))};
      cyc();
      n_vec++; if (seg_pos !== exp_pos()) begin n_err++; $display("FAIL rnd_pos: got %h want %h", seg_pos, exp_pos()); end
      n_vec++; if (seg_dir !== exp_dir()) begin n_err++; $display("FAIL rnd_dir: got %h want %h", seg_dir, exp_dir()); end
      n_vec++; if (length !== 4'(m_len)) begin n_err++; $display("FAIL rnd_len: got %0d want %0d", length, m_len); end
      n_vec++; if (seg_active !== exp_active()) begin n_err++; $display("FAIL rnd_active: got %b want %b", seg_active, exp_active()); end
      n_vec++; if (body_full !== (m_len == MAXS) || body_empty !== (m_len == 0)) begin
        n_err++; $display("FAIL rnd_fullempty: got %b%b len %0d", body_full, body_empty, m_len);
      end
      n_vec++; if (move_event !== m_move) begin n_err++; $display("FAIL rnd_move: got %b want %b", move_event, m_move); end
      n_vec++; if (query_hit !== m_qhit || query_index !== 4'(m_qidx)) begin
        n_err++; $display("FAIL rnd_query: got %b/%0d want %b/%0d", query_hit, query_index, m_qhit, m_qidx);
      end
      n_vec++; if (head_overlap !== m_ovl) begin n_err++; $display("FAIL rnd_overlap: got %b want %b", head_overlap, m_ovl); end
    end
    grow = 0; shrink = 0;
  endtask

  initial begin
    test_reset();
    test_path();
    test_saturation();
    test_simultaneous();
    test_query();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dragon_body.md
Name: dragon_body

Overview:
- Downstream stage of the dragon head movement block.
- Consumes the head's tile position and facing direction and keeps a trail of body segments that follow one step behind each other.
- Exposes per-segment position, direction and active flags for the renderer and collision logic.
- Supports growing and shrinking the visible body, and answers tile-occupancy queries.

Parameters:
- MAX_SEGMENTS, 8: number of trail slots held (1..15).
- INIT_LENGTH, 3: active segment count after reset (0..MAX_SEGMENTS).
- RESET_POS, 8'h00: position loaded into every slot at reset ({x[3:0], y[3:0]}, top-left).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- head_pos  in  8  head tile position {x[7:4], y[3:0]}
- head_dir  in  2  head facing: 00 up, 01 right, 10 down, 11 left
- grow  in  1  single-cycle pulse: add one segment
- shrink  in  1  single-cycle pulse: remove one segment (e.g. dragon hit)
- query_pos  in  8  tile to test for body occupancy
- seg_pos  out  8*MAX_SEGMENTS  packed slot positions; slot 0 in bits [7:0], nearest the head
- seg_dir  out  2*MAX_SEGMENTS  packed slot directions; slot 0 in bits [1:0]
- seg_active  out  MAX_SEGMENTS  bit i = 1 when i < length
- length  out  4  current active segment count
- body_full  out  1  length == MAX_SEGMENTS
- body_empty  out  1  length == 0
- move_event  out  1  one-cycle pulse when the trail shifted
- query_hit  out  1  query_pos matches an active segment
- query_index  out  4  lowest matching active slot index; 0 when no hit
- head_overlap  out  1  head_pos matches an active segment (self-collision)

Behaviour:
- Reset (async, immediate):
  - all slots = RESET_POS, all dirs = 00
  - prev_head = RESET_POS, prev_dir = 00
  - length = INIT_LENGTH
  - move_event, query_hit, query_index, head_overlap = 0
- Move detection:
  - prev_head/prev_dir are registered copies of head_pos/head_dir, updated every cycle.
  - A move occurs on a cycle where head_pos != prev_head.
- On a move edge:
  - slot[0] <= prev_head, dir[0] <= prev_dir.
  - slot[i] <= slot[i-1], dir[i] <= dir[i-1] for i = 1..MAX-1.
  - The old slot[MAX-1] is discarded.
  - move_event = 1 for exactly the following cycle.
- All MAX slots always shift, active or not, so inactive slots hold real trail history.
- A change to head_dir alone (same position) does not shift the trail.
- Length control, evaluated each edge:
  - grow only: length+1, saturating at MAX_SEGMENTS.
  - shrink only: length-1, saturating at 0.
  - grow and shrink together: length unchanged.
  - Grow/shrink combined with a move: both apply on the same edge. The newly active slot shows its post-shift contents.
- seg_active and body_full/body_empty are combinational from length. seg_pos and seg_dir are direct register outputs.
- Query path (1-cycle latency, registered):
  - query_hit/query_index reflect query_pos and the active slots as sampled at the previous edge (pre-update state).
  - Inactive slots never match.
  - When several slots match, the lowest index wins.
- head_overlap (registered, 1-cycle latency): set when head_pos equals any active slot in the pre-update state.
- Head reset: if the upstream head jumps to 00 while this block is not in reset, that is an ordinary move (the trail shifts). Only the reset pin clears the trail.
- Reset asserted mid-operation overrides grow, shrink, moves and queries immediately. The first move after reset release is judged against prev_head = RESET_POS.

Test Plan:
1. Reset check: assert reset, then release with head_pos = 00 held.
   - Required: all seg_pos = 00, length = 3, seg_active = 8'b0000_0111, no move_event.
2. Head path 00 -> 10 -> 20 -> 21, one change per 4 cycles.
   - Required: after the third move, slot0 = 20, slot1 = 10, slot2 = 00.
   - Required: dir propagates the same way; move_event pulses exactly 3 times.
3. Saturation: grow pulsed 7 times.
   - Required: length = 8, body_full = 1.
   - Then shrink 9 times: length = 0, body_empty = 1, seg_active = 0.
4. Simultaneous events:
   - grow and shrink on the same edge: length unchanged.
   - grow coinciding with a move at length 3: length = 4, slot3 = the old slot2 value.
5. Query: trail slots 0..2 = 20, 10, 00 with length = 2.
   - query_pos = 10: query_hit = 1, query_index = 1 one cycle later.
   - query_pos = 00: query_hit = 0 (slot 2 inactive).
   - head_pos driven onto 20: head_overlap = 1 the next cycle.
6. Mid-operation reset: assert reset asynchronously between edges at length 5.
   - Required: outputs return to reset values before the next clk edge.
   - Required: the trail stays at 00 until the head moves.
